// File: rtl/alsu_chk_pkg.sv
// Shared types and widths for the ALSU result checker: FSM states, the
// delayed-context record and the 53-bit mismatch log entry.
package alsu_chk_pkg;

    localparam int unsigned STAMP_W = 16;
    localparam int unsigned ENTRY_W = 53;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPND_W  = 3;
    localparam int unsigned OUT_W   = 6;
    localparam int unsigned LEDS_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_HALT   = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } chk_ctx_t;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [OPC_W-1:0]   opcode;
        logic [OPND_W-1:0]  a;
        logic [OPND_W-1:0]  b;
        logic [OUT_W-1:0]   out;
        logic [OUT_W-1:0]   out_ref;
        logic [LEDS_W-1:0]  leds_diff;
    } chk_entry_t;

endpackage

// File: rtl/alsu_chk_fifo.sv
// Synchronous FIFO of mismatch entries; full-with-push-and-no-pop drops the
// entry and pulses o_drop_c. i_clear discards pointers and any same-cycle push/pop.
module alsu_chk_fifo
    import alsu_chk_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_push,
    input  chk_entry_t i_data,
    output logic       o_full,
    input  logic       i_pop,
    output logic       o_valid,
    output chk_entry_t o_data,
    output logic       o_drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    chk_entry_t  r_mem [DEPTH];
    logic        w_pop;
    logic        w_wr;

    // Extra pointer MSB distinguishes full from empty.
    assign o_valid  = (r_wr_ptr != r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = i_pop && o_valid && !i_clear;
    assign w_wr     = i_push && !i_clear && (!o_full || w_pop);
    assign o_drop_c = i_push && !i_clear && o_full && !w_pop;
    assign o_data   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/alsu_result_checker.sv
// Compares ALSU out/leds against the reference, counts matches/mismatches and
// logs mismatches with their aligned context. Define ALSU_CHK_STOP_EN to halt on the first mismatch.
module alsu_result_checker
    import alsu_chk_pkg::*;
#(
    parameter int unsigned LAT       = 2,
    parameter int unsigned LOG_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic signed [2:0]   A,
    input  logic signed [2:0]   B,
    input  logic [2:0]          opcode,
    input  logic [5:0]          out,
    input  logic [5:0]          out_ref,
    input  logic [15:0]         leds,
    input  logic [15:0]         leds_ref,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [ENTRY_W-1:0]  log_data,
    output logic [CNT_W-1:0]    match_cnt,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic                overflow,
    output logic                busy,
    output logic                halted
);

    localparam int unsigned WARM_W = 3;

    chk_state_e          r_state;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic                r_busy;
    logic                r_halted;
    chk_ctx_t            r_ctx [LAT];
    logic [STAMP_W-1:0]  r_stamp;
    logic [CNT_W-1:0]    r_match_cnt;
    logic [CNT_W-1:0]    r_mismatch_cnt;
    logic                r_overflow;

    logic                w_run;
    logic                w_differs;
    logic                w_match;
    logic                w_mismatch;
    logic                w_drop;
    logic                w_full;
    chk_entry_t          w_entry;
    chk_entry_t          w_head;

    assign w_run      = (r_state == S_RUN) && !clear;
    assign w_differs  = (out != out_ref) || (leds != leds_ref);
    assign w_match    = w_run && !w_differs;
    assign w_mismatch = w_run && w_differs;

    assign w_entry = '{stamp:     r_stamp,
                       opcode:    r_ctx[LAT-1].opcode,
                       a:         r_ctx[LAT-1].a,
                       b:         r_ctx[LAT-1].b,
                       out:       out,
                       out_ref:   out_ref,
                       leds_diff: leds ^ leds_ref};

    // Context pipe aligns the operands/opcode with the result LAT cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                r_ctx[i] <= '0;
            end
        end else begin
            r_ctx[0] <= '{opcode: opcode, a: A, b: B};
            for (int unsigned i = 1; i < LAT; i++) begin
                r_ctx[i] <= r_ctx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_warm_cnt <= '0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else if (clear) begin
            r_warm_cnt <= '0;
            r_halted   <= 1'b0;
            r_state    <= enable ? S_WARMUP : S_IDLE;
            r_busy     <= enable;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state    <= S_WARMUP;
                        r_busy     <= 1'b1;
                        r_warm_cnt <= '0;
                    end
                end
                S_WARMUP: begin
                    if (r_warm_cnt == WARM_W'(LAT - 1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
                    end
                end
                S_RUN: begin
`ifdef ALSU_CHK_STOP_EN
                    if (w_differs) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else
`endif
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters, RUN-cycle stamp and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stamp        <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
        end else if (clear) begin
            r_stamp        <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_run) begin
                r_stamp <= r_stamp + STAMP_W'(1);
            end
            if (w_match && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            if (w_mismatch && (r_mismatch_cnt != '1)) begin
                r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    alsu_chk_fifo #(
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .i_clear  (clear),
        .i_push   (w_mismatch),
        .i_data   (w_entry),
        .o_full   (w_full),
        .i_pop    (log_ready),
        .o_valid  (log_valid),
        .o_data   (w_head),
        .o_drop_c (w_drop)
    );

    assign log_data     = w_head;
    assign match_cnt    = r_match_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign overflow     = r_overflow;
    assign busy         = r_busy;
    assign halted       = r_halted;

endmodule
